// File: rtl/stage_sequencer_pkg.sv
// Shared decode definitions for the stage sequencer: field positions,
// the call condition code, instruction classes and stage-count encoding.
package stage_sequencer_pkg;

  // Instruction field positions (16-bit instruction word).
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int CC_HI   = 11;
  localparam int CC_LO   = 8;
  localparam int CSRC_HI = 15;
  localparam int CSRC_LO = 6;
  localparam int MODE_HI = 5;
  localparam int MODE_LO = 2;
  localparam int IMM_BIT = 0;

  // Field encodings.
  localparam logic [3:0] OPC_BRANCH       = 4'h0;
  localparam logic [3:0] CC_CALL          = 4'hF;
  localparam logic [9:0] CALL_SRC_PATTERN = 10'b0010000001;
  localparam logic [3:0] MODE_IMM         = 4'h0;

  // Stage-count encoding per instruction class.
  localparam int unsigned STAGES_SINGLE = 1;
  localparam int unsigned STAGES_CALL   = 2;

  typedef enum logic [1:0] {
    CLS_PLAIN       = 2'd0,
    CLS_CALL_BRANCH = 2'd1,
    CLS_CALL_SRC    = 2'd2
  } inst_class_e;

  function automatic logic is_branch(input logic [15:0] inst);
    return inst[OPC_HI:OPC_LO] == OPC_BRANCH;
  endfunction

  function automatic inst_class_e classify(input logic [15:0] inst);
    if (is_branch(inst) && inst[CC_HI:CC_LO] == CC_CALL)
      return CLS_CALL_BRANCH;
    else if (inst[CSRC_HI:CSRC_LO] == CALL_SRC_PATTERN)
      return CLS_CALL_SRC;
    else
      return CLS_PLAIN;
  endfunction

  function automatic int unsigned raw_stages(input inst_class_e cls);
    case (cls)
      CLS_CALL_BRANCH,
      CLS_CALL_SRC:    return STAGES_CALL;
      default:         return STAGES_SINGLE;
    endcase
  endfunction

  // An immediate operand (imm16 or [imm16]) occupies an extra word after the opcode.
  function automatic logic [1:0] plus_pc_words(input logic [15:0] inst);
    if (!is_branch(inst) && inst[MODE_HI:MODE_LO] == MODE_IMM && inst[IMM_BIT])
      return 2'd2;
    else
      return 2'd1;
  endfunction

endpackage

// File: rtl/stage_sequencer_inst_fifo.sv
// Instruction buffer: circular FIFO with power-of-two depth, occupancy
// count and a synchronous flush that empties it on the next edge.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // Storage write on accepted push.
  // NOTE: the data array has no reset; occupancy is tracked by count/pointers,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Stage sequencer: buffers prefetched instructions and presents the head
// instruction to the scheduler one decode stage at a time, retiring it
// after its last stage. Flush discards everything buffered.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_STAGES = 4,
  parameter int INST_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [INST_BITS-1:0]          in_inst,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          uop_valid,
  output logic [INST_BITS-1:0]          uop_inst,
  output logic [$clog2(MAX_STAGES)-1:0] uop_stage,
  output logic                          uop_pre,
  output logic [1:0]                    uop_plus_pc_words,
  input  logic                          uop_done,
  output logic                          inst_done,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int SW = $clog2(MAX_STAGES);
  localparam int NW = SW + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [SW-1:0] STAGE_ONE = SW'(1);
  localparam logic [NW-1:0] N_ONE     = NW'(1);

  logic [INST_BITS-1:0] head_inst;
  logic [CW-1:0]        fifo_count;
  logic [SW-1:0]        stage_q;
  logic [NW-1:0]        n_stages;
  logic                 stage_is_last;
  logic                 done_fire;
  logic                 last_fire;
  logic                 push;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_BITS)
  ) u_inst_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (last_fire),
    .flush   (flush),
    .wdata   (in_inst),
    .rdata   (head_inst),
    .count   (fifo_count)
  );

  // Stage count of the head instruction, clamped to the configured maximum.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    int unsigned raw;
    raw = raw_stages(classify(head_inst[15:0]));
    if (raw > MAX_STAGES)
      raw = MAX_STAGES;
    n_stages = NW'(raw);
  end

  assign in_ready      = fifo_count < DEPTH_C;
  assign push          = in_valid && in_ready && !flush;
  assign uop_valid     = fifo_count != '0;
  assign stage_is_last = {1'b0, stage_q} == (n_stages - N_ONE);
  assign done_fire     = uop_valid && uop_done;
  assign last_fire     = done_fire && stage_is_last;

  assign uop_inst          = head_inst;
  assign uop_stage         = stage_q;
  assign uop_pre           = uop_valid && !stage_is_last;
  assign uop_plus_pc_words = plus_pc_words(head_inst[15:0]);
  assign inst_done         = last_fire;
  assign count             = fifo_count;

  // Stage counter: advances on a non-last uop_done, returns to 0 on retire or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stage_q <= '0;
    else if (flush || last_fire)
      stage_q <= '0;
    else if (done_fire)
      stage_q <= stage_q + STAGE_ONE;
  end

endmodule
